// File: rtl/dota_scan_ctrl.sv
// dota_scan_ctrl: time-shares one OTA/comparator macro across up to NCH mux channels.
// Scans the masked channels lowest-first: select, settle, sample, then presents the
// per-channel decision word over a valid/ready handshake.
// Optional build macro DOTA_SCAN_MAJORITY_EN: 3-sample majority vote per channel
// (default build takes a single sample).
module dota_scan_ctrl #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned SELW       = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [NCH-1:0]  ch_mask,
  output logic [SELW-1:0] mux_sel,
  output logic            ota_en,
  input  logic            ota_out,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NCH-1:0]  res_data
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StSettle, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic [NCH-1:0]  rem_q, rem_d;
  logic [NCH-1:0]  res_q, res_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            sample_last;
  logic            decision;
  logic [NCH-1:0]  rem_left;

  // Lowest set bit of a channel mask.
  function automatic logic [SELW-1:0] lowest_ch(input logic [NCH-1:0] m);
    logic [SELW-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = SELW'(i);
    end
    return r;
  endfunction

  // Remaining mask once the current channel has been decided.
  assign rem_left = rem_q & ~({{(NCH-1){1'b0}}, 1'b1} << sel_q);

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ota_out;
      sync2_q <= sync1_q;
    end
  end

`ifdef DOTA_SCAN_MAJORITY_EN
  logic [1:0] samp_q, samp_d;
  logic [1:0] votes_q, votes_d;

  // Sample counter and running vote; both restart whenever SAMPLE is not active.
  always_comb begin
    samp_d  = 2'd0;
    votes_d = 2'd0;
    if (state_q == StSample) begin
      samp_d  = samp_q + 2'd1;
      votes_d = votes_q + {1'b0, sync2_q};
    end
  end

  // Vote state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q  <= 2'd0;
      votes_q <= 2'd0;
    end else begin
      samp_q  <= samp_d;
      votes_q <= votes_d;
    end
  end

  assign sample_last = (samp_q == 2'd2);
  assign decision    = (({1'b0, votes_q} + {2'b00, sync2_q}) >= 3'd2);
`else
  assign sample_last = 1'b1;
  assign decision    = sync2_q;
`endif

  // Next-state logic for the scan sequencer; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    res_d   = res_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start && (|ch_mask)) begin
          rem_d   = ch_mask;
          res_d   = '0;
          sel_d   = lowest_ch(ch_mask);
          state_d = StSelect;
        end
      end
      StSelect: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) state_d = StSample;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      StSample: begin
        if (sample_last) begin
          res_d[sel_q] = decision;
          rem_d        = rem_left;
          if (|rem_left) begin
            sel_d   = lowest_ch(rem_left);
            state_d = StSelect;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      rem_d   = '0;
      res_d   = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mux_sel   = sel_q;
  assign ota_en    = (state_q == StSelect) || (state_q == StSettle) || (state_q == StSample);
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign res_data  = res_q;

endmodule

// File: tb/tb_dota_scan_ctrl.sv
// Self-checking bench for dota_scan_ctrl (NCH=4, SETTLE_CYC=8).
// Honours DOTA_SCAN_MAJORITY_EN to pick the per-channel sample count.
module tb_dota_scan_ctrl;

  localparam int SETTLE = 8;
`ifdef DOTA_SCAN_MAJORITY_EN
  localparam int S       = 3;
  localparam int PULSE_C = 8;
  localparam logic [3:0] GLITCH_EXP = 4'b0000;
`else
  localparam int S       = 1;
  localparam int PULSE_C = 7;
  localparam logic [3:0] GLITCH_EXP = 4'b0010;
`endif
  localparam int PER = 1 + SETTLE + S;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, res_ready;
  logic [3:0] ch_mask;
  logic [1:0] mux_sel;
  logic       ota_en, ota_out, busy, res_valid;
  logic [3:0] res_data;

  // Analog environment: comparator output follows the selected channel, or a manual level.
  logic       ota_mode;
  logic [3:0] ota_tbl;
  logic       ota_manual;

  int n_checks = 0;
  int n_pass   = 0;

  dota_scan_ctrl #(.NCH(4), .SETTLE_CYC(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ch_mask  (ch_mask),
    .mux_sel  (mux_sel),
    .ota_en   (ota_en),
    .ota_out  (ota_out),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data)
  );

  always #5 clk = ~clk;

  always_comb ota_out = ota_mode ? ota_manual : ota_tbl[mux_sel];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] bits;
    int         hold;
    logic [3:0] exp_data;
    int         exp_k;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: channels are visited in ascending order; each decision is the channel's level.
  function automatic void model_scan(input logic [3:0] mask, input logic [3:0] bits,
                                     output logic [3:0] exp_data, output int k,
                                     output logic [31:0] seq_enc);
    exp_data = mask & bits;
    k        = 0;
    seq_enc  = 0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        k++;
        seq_enc = seq_enc * 8 + 32'(i + 1);
      end
    end
  endfunction

  task automatic do_scan(input logic [3:0] mask, input logic [3:0] bits, input int hold,
                         input logic [3:0] exp_data, input int exp_k, input string name);
    int          lat;
    int          unstable;
    logic [1:0]  seq[$];
    logic [3:0]  held;
    logic [31:0] seq_enc;
    logic [31:0] exp_enc;
    logic [3:0]  dummy_data;
    int          dummy_k;
    model_scan(mask, 4'b0000, dummy_data, dummy_k, exp_enc);
    ota_mode = 1'b0;
    ota_tbl  = bits;
    ch_mask  = mask;
    start    = 1'b1;
    tick();
    start   = 1'b0;
    ch_mask = 4'($urandom);
    check({name, " busy_rise"}, busy, 1);
    lat = 0;
    while (!res_valid && lat < 400) begin
      if (ota_en && (seq.size() == 0 || mux_sel != seq[$])) seq.push_back(mux_sel);
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_k * PER);
    seq_enc = 0;
    foreach (seq[i]) seq_enc = seq_enc * 8 + 32'(seq[i]) + 1;
    check({name, " mux_seq"}, seq_enc, exp_enc);
    check({name, " res_data"}, res_data, exp_data);
    check({name, " ota_off_done"}, ota_en, 0);
    if (hold > 0) begin
      held     = res_data;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        res_ready = 1'b0;
        ch_mask   = 4'b1111;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (!res_valid || res_data !== held || !busy) unstable++;
      end
      check({name, " hold_stable"}, unstable, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, " idle_after_xfer"}, {busy, res_valid}, 0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [3:0]  m_data;
    int          m_k;
    logic [31:0] m_enc;
    int          cnt;
    int          lat;

    vecs[0] = '{mask: 4'b0101, bits: 4'b0001, hold: 0, exp_data: 4'b0001, exp_k: 2};
    vecs[1] = '{mask: 4'b0101, bits: 4'b0001, hold: 5, exp_data: 4'b0001, exp_k: 2};
    vecs[2] = '{mask: 4'b1111, bits: 4'b1010, hold: 0, exp_data: 4'b1010, exp_k: 4};
    vecs[3] = '{mask: 4'b1000, bits: 4'b1111, hold: 1, exp_data: 4'b1000, exp_k: 1};
    vecs[4] = '{mask: 4'b0110, bits: 4'b1101, hold: 2, exp_data: 4'b0100, exp_k: 2};
    vecs[5] = '{mask: 4'b0001, bits: 4'b0000, hold: 0, exp_data: 4'b0000, exp_k: 1};

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    res_ready  = 1'b0;
    ch_mask    = 4'b0000;
    ota_mode   = 1'b0;
    ota_tbl    = 4'b0000;
    ota_manual = 1'b0;
    #3;
    check("reset_state", {mux_sel, ota_en, busy, res_valid, res_data}, 0);
    #9;
    rst = 1'b0;
    tick();

    // Start with an empty mask is ignored.
    ch_mask = 4'b0000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || res_valid) cnt++;
      tick();
    end
    check("zero_mask_ignored", cnt, 0);

    for (int v = 0; v < 6; v++) begin
      do_scan(vecs[v].mask, vecs[v].bits, vecs[v].hold, vecs[v].exp_data, vecs[v].exp_k,
              $sformatf("vec%0d", v));
    end

    // Abort during SAMPLE wins over res_ready.
    ota_mode = 1'b0;
    ota_tbl  = 4'b0001;
    ch_mask  = 4'b0001;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (1 + SETTLE) tick();
    check("abort_pre_ota_en", ota_en, 1);
    abort     = 1'b1;
    res_ready = 1'b1;
    tick();
    abort     = 1'b0;
    res_ready = 1'b0;
    check("abort_outputs", {busy, ota_en, res_valid, res_data}, 0);
    cnt = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      if (res_valid || busy) cnt++;
      tick();
    end
    check("abort_no_result", cnt, 0);

    // Asynchronous reset during SETTLE of channel 2.
    ota_tbl = 4'b1111;
    ch_mask = 4'b1111;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * PER + 3) tick();
    check("pre_reset_ch2", {ota_en, mux_sel}, {1'b1, 2'd2});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {mux_sel, ota_en, busy, res_valid, res_data}, 0);
    #1;
    rst = 1'b0;
    tick();
    do_scan(4'b1111, 4'b0110, 0, 4'b0110, 4, "post_reset");

    // One-cycle comparator pulse timed onto the sample window.
    ota_mode   = 1'b1;
    ota_manual = 1'b0;
    ch_mask    = 4'b0010;
    start      = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!res_valid && lat < 400) begin
      ota_manual = (lat == PULSE_C);
      tick();
      lat++;
    end
    ota_manual = 1'b0;
    check("pulse_latency", lat, PER);
    check("pulse_res_data", res_data, GLITCH_EXP);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    ota_mode  = 1'b0;

    // Randomized scans against the reference model.
    for (int r = 0; r < 20; r++) begin
      logic [3:0] rm;
      logic [3:0] rb;
      rm = 4'($urandom_range(1, 15));
      rb = 4'($urandom);
      model_scan(rm, rb, m_data, m_k, m_enc);
      do_scan(rm, rb, $urandom_range(0, 2), m_data, m_k, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dota_scan_ctrl.md
# dota_scan_ctrl

Scan controller that time-shares one digital OTA/comparator macro between up to NCH analog input pairs. It steps an external analog mux through the channels enabled in a mask, enables the OTA, and waits a settle interval. It then samples the comparator output and collects one decision bit per channel into a result word. The result word is returned over a valid/ready handshake. It sits between the tile's digital control logic (ui_in/uio) and the analog mux plus OTA enable in front of ua[0]/ua[1].

## Interface
- NCH, default 4: number of multiplexed channels; range 2..8.
- SETTLE_CYC, default 8: settle cycles after mux switch; must be ≥2 to cover the synchronizer.
- SELW, default $clog2(NCH): mux select width (derived).

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  scan request; accepted only in IDLE.
- abort  in  1  synchronous scan cancel.
- ch_mask  in  NCH  channels to scan; latched when start is accepted.
- mux_sel  out  SELW  analog mux select.
- ota_en  out  1  OTA enable (tri-state output driver enable).
- ota_out  in  1  raw comparator output, asynchronous to clk.
- busy  out  1  high from start acceptance until result transfer or abort.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  NCH  per-channel decision bits; unmasked bits are 0.

## Operation
- ota_out passes through a 2-flop synchronizer. Only the synchronized value is used.
- States: IDLE, SELECT, SETTLE, SAMPLE, DONE.
- IDLE: start=1 and ch_mask≠0 → latch mask, clear result register, go to SELECT. start with ch_mask=0 is ignored.
- SELECT (1 cycle): mux_sel ← lowest remaining masked channel; ota_en=1.
- SETTLE: counter runs SETTLE_CYC cycles, then → SAMPLE.
- SAMPLE: S cycles (see Configuration). The decision is written to res_data[ch] and the channel is cleared from the remaining mask.
  - Remaining mask ≠0 → SELECT.
  - Otherwise → DONE.
- DONE: ota_en=0, res_valid=1; res_data and mux_sel are held stable. Transfer occurs when res_valid & res_ready; then → IDLE with busy=0 on the following cycle.
- start in any non-IDLE state is ignored; it is not queued.
- abort in SELECT/SETTLE/SAMPLE/DONE → IDLE next edge.
  - ota_en, res_valid and busy go to 0.
  - res_data is cleared; no result is produced.
  - abort has priority over res_ready in the same cycle.
- mux_sel is held constant between SELECT and the end of SAMPLE; it never changes while ota_en=1 outside SELECT.
- Reset mid-scan: all state is cleared immediately (async). Behaviour after reset is identical to power-up.

## Timing
- Reset values: mux_sel=0, ota_en=0, busy=0, res_valid=0, res_data=0, state=IDLE, synchronizer flops=0.
- busy rises the cycle after the edge that accepts start.
- Per-channel time: 1 + SETTLE_CYC + S cycles.
- res_valid rises k·(1+SETTLE_CYC+S) cycles after start acceptance, where k = popcount(ch_mask).
- Maximum result rate: one scan per k·(1+SETTLE_CYC+S)+2 cycles when res_ready is held high.
- Settle counter width is $clog2(SETTLE_CYC+1); it does not wrap within a channel.

## Configuration
- DOTA_SCAN_MAJORITY_EN defined:
  - S=3; synchronized ota_out is sampled on 3 consecutive cycles.
  - Decision = majority (≥2 ones).
  - Rejects single-cycle comparator glitches.
- Undefined:
  - S=1; a single sample on the SAMPLE cycle is the decision.
  - The vote logic and sample counter are removed.

## Test plan
- Reset during SETTLE of channel 2 (mask 4'b1111) → all outputs return to reset values asynchronously. A new start afterwards scans from channel 0.
- NCH=4, SETTLE_CYC=8, no macro, ch_mask=4'b0101, ota_out=1 on ch0 and 0 on ch2:
  - mux_sel sequence 0 then 2.
  - res_valid after 20 cycles.
  - res_data=4'b0001.
- Same stimulus with res_ready held low for 5 cycles → res_valid and res_data stay stable; a second start is ignored. Transfer on ready; busy=0 next cycle.
- Macro defined, ch_mask=4'b0010, ota_out pulses to 1 for exactly one synchronized SAMPLE cycle → res_data=4'b0000; latency 12 cycles.
- start with ch_mask=0 → busy stays 0, no res_valid.
- abort asserted in SAMPLE with res_ready=1 → no transfer; busy, ota_en and res_valid=0 next cycle; res_data=0.
